// File: rtl/fpu_operand_align.sv
// fpu_operand_align: classifies an FP operand pair, orders it by magnitude and
// right-aligns the smaller mantissa, or resolves the special case, for the adder.
module fpu_operand_align #(
   parameter int SHIFT_STEP = 4,
   parameter int MAX_SHIFT  = 28
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] op_A_in,
   input  logic [31:0] op_B_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [27:0] mant_big,
   output logic [27:0] mant_small,
   output logic        sticky,
   output logic [5:0]  exp_out,
   output logic        sign_big,
   output logic        eff_sub,
   output logic        swapped,
   output logic        special,
   output logic [31:0] special_result,
   output logic [3:0]  status_out
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_CLASSIFY = 2'd1;
   localparam logic [1:0] S_ALIGN    = 2'd2;
   localparam logic [1:0] S_HOLD     = 2'd3;

   localparam logic [4:0]  STEP = 5'(SHIFT_STEP);
   localparam logic [5:0]  DMAX = 6'(MAX_SHIFT);
   localparam logic [31:0] QNAN = 32'h7FFF_FFFF;

   logic [1:0]  state_q, state_d;
   logic [31:0] opa_q, opa_d;
   logic [31:0] opb_q, opb_d;
   logic [27:0] mbig_q, mbig_d;
   logic [27:0] msml_q, msml_d;
   logic        stk_q, stk_d;
   logic [5:0]  exp_q, exp_d;
   logic        sgn_q, sgn_d;
   logic        esub_q, esub_d;
   logic        swp_q, swp_d;
   logic        spc_q, spc_d;
   logic [31:0] sres_q, sres_d;
   logic [3:0]  stat_q, stat_d;
   logic [4:0]  rem_q, rem_d;

   logic        sa, sb;
   logic [5:0]  ea, eb;
   logic [24:0] ma, mb;
   logic        a_zero, a_inf, a_nan;
   logic        b_zero, b_inf, b_nan;
   logic        b_gt;
   logic [27:0] ext_a, ext_b;
   logic [5:0]  e_big, e_sml, d_raw, d_clp;
   logic [4:0]  s;
   logic [27:0] out_mask;

   assign {sa, ea, ma} = opa_q;
   assign {sb, eb, mb} = opb_q;

   assign a_zero = (ea == 6'd0);
   assign b_zero = (eb == 6'd0);
   assign a_inf  = (&ea) && (ma == 25'd0);
   assign b_inf  = (&eb) && (mb == 25'd0);
   assign a_nan  = (&ea) && (ma != 25'd0);
   assign b_nan  = (&eb) && (mb != 25'd0);

   // exponent sits above mantissa, so one unsigned compare orders magnitudes
   assign b_gt  = opb_q[30:0] > opa_q[30:0];
   assign ext_a = {1'b1, ma, 2'b00};
   assign ext_b = {1'b1, mb, 2'b00};
   assign e_big = b_gt ? eb : ea;
   assign e_sml = b_gt ? ea : eb;
   assign d_raw = e_big - e_sml;
   assign d_clp = (d_raw > DMAX) ? DMAX : d_raw;

   assign s        = (rem_q > STEP) ? STEP : rem_q;
   assign out_mask = ~(28'hFFF_FFFF << s);

   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      mbig_d  = mbig_q;
      msml_d  = msml_q;
      stk_d   = stk_q;
      exp_d   = exp_q;
      sgn_d   = sgn_q;
      esub_d  = esub_q;
      swp_d   = swp_q;
      spc_d   = spc_q;
      sres_d  = sres_q;
      stat_d  = stat_q;
      rem_d   = rem_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               opa_d   = op_A_in;
               opb_d   = op_B_in;
               state_d = S_CLASSIFY;
            end
         end
         S_CLASSIFY: begin
            esub_d  = sa ^ sb;
            mbig_d  = 28'd0;
            msml_d  = 28'd0;
            stk_d   = 1'b0;
            exp_d   = 6'd0;
            sgn_d   = 1'b0;
            swp_d   = 1'b0;
            spc_d   = 1'b1;
            sres_d  = 32'd0;
            stat_d  = 4'd0;
            rem_d   = 5'd0;
            state_d = S_HOLD;
            if (a_nan || b_nan) begin
               sres_d = QNAN;
               stat_d = 4'b1001;
            end else if (a_inf && b_inf && (sa != sb)) begin
               sres_d = QNAN;
               stat_d = 4'b0001;
            end else if (a_inf || b_inf) begin
               sres_d = a_inf ? opa_q : opb_q;
               stat_d = 4'b0010;
            end else if (a_zero && b_zero) begin
               sres_d = {sa & sb, 31'd0};
               stat_d = 4'b0100;
            end else if (a_zero) begin
               sres_d = opb_q;
            end else if (b_zero) begin
               sres_d = opa_q;
            end else begin
               spc_d  = 1'b0;
               swp_d  = b_gt;
               sgn_d  = b_gt ? sb : sa;
               exp_d  = e_big;
               mbig_d = b_gt ? ext_b : ext_a;
               msml_d = b_gt ? ext_a : ext_b;
               rem_d  = d_clp[4:0];
               if (d_clp != 6'd0) state_d = S_ALIGN;
            end
         end
         S_ALIGN: begin
            msml_d = msml_q >> s;
            stk_d  = stk_q | (|(msml_q & out_mask));
            rem_d  = rem_q - s;
            if (rem_q == s) state_d = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         opa_q   <= 32'd0;
         opb_q   <= 32'd0;
         mbig_q  <= 28'd0;
         msml_q  <= 28'd0;
         stk_q   <= 1'b0;
         exp_q   <= 6'd0;
         sgn_q   <= 1'b0;
         esub_q  <= 1'b0;
         swp_q   <= 1'b0;
         spc_q   <= 1'b0;
         sres_q  <= 32'd0;
         stat_q  <= 4'd0;
         rem_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         mbig_q  <= mbig_d;
         msml_q  <= msml_d;
         stk_q   <= stk_d;
         exp_q   <= exp_d;
         sgn_q   <= sgn_d;
         esub_q  <= esub_d;
         swp_q   <= swp_d;
         spc_q   <= spc_d;
         sres_q  <= sres_d;
         stat_q  <= stat_d;
         rem_q   <= rem_d;
      end
   end

   assign in_ready       = (state_q == S_IDLE);
   assign out_valid      = (state_q == S_HOLD);
   assign mant_big       = mbig_q;
   assign mant_small     = msml_q;
   assign sticky         = stk_q;
   assign exp_out        = exp_q;
   assign sign_big       = sgn_q;
   assign eff_sub        = esub_q;
   assign swapped        = swp_q;
   assign special        = spc_q;
   assign special_result = sres_q;
   assign status_out     = stat_q;

endmodule

// File: tb/tb_fpu_operand_align.sv
// Testbench for fpu_operand_align: directed cases plus random pairs checked
// against an arithmetic reference model.
module tb_fpu_operand_align;

   localparam int STEP = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [27:0] mant_big, mant_small;
   logic        sticky;
   logic [5:0]  exp_out;
   logic        sign_big, eff_sub, swapped, special;
   logic [31:0] special_result;
   logic [3:0]  status_out;

   int checks = 0;
   int errors = 0;

   fpu_operand_align #(.SHIFT_STEP(STEP), .MAX_SHIFT(28)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_A_in(op_a), .op_B_in(op_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .mant_big(mant_big), .mant_small(mant_small), .sticky(sticky),
      .exp_out(exp_out), .sign_big(sign_big), .eff_sub(eff_sub),
      .swapped(swapped), .special(special),
      .special_result(special_result), .status_out(status_out)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [27:0] mb, ms;
      logic        st;
      logic [5:0]  e;
      logic        sb, es, sw, sp;
      logic [31:0] sr;
      logic [3:0]  stt;
      int          lat;
   } exp_t;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic exp_t model(logic [31:0] a, logic [31:0] b);
      exp_t r;
      int ea, eb, eB, eS, d;
      longint ma, mb;
      bit za, zb, ia, ib, na, nb, bbig;
      logic [27:0] xs;
      logic [55:0] w;
      ea = int'(a[30:25]); eb = int'(b[30:25]);
      ma = longint'(a[24:0]); mb = longint'(b[24:0]);
      za = (ea == 0); zb = (eb == 0);
      ia = (ea == 63) && (ma == 0); ib = (eb == 63) && (mb == 0);
      na = (ea == 63) && (ma != 0); nb = (eb == 63) && (mb != 0);
      r.mb = 0; r.ms = 0; r.st = 0; r.e = 0; r.sb = 0; r.sw = 0;
      r.sp = 1; r.sr = 0; r.stt = 0; r.lat = 1;
      r.es = a[31] ^ b[31];
      if (na || nb) begin
         r.sr = 32'h7FFFFFFF; r.stt = 4'b1001;
      end else if (ia && ib && (a[31] != b[31])) begin
         r.sr = 32'h7FFFFFFF; r.stt = 4'b0001;
      end else if (ia || ib) begin
         r.sr = ia ? a : b; r.stt = 4'b0010;
      end else if (za && zb) begin
         r.sr = {a[31] & b[31], 31'd0}; r.stt = 4'b0100;
      end else if (za) begin
         r.sr = b;
      end else if (zb) begin
         r.sr = a;
      end else begin
         r.sp = 0;
         bbig = (eb > ea) || (eb == ea && mb > ma);
         r.sw = bbig;
         eB = bbig ? eb : ea;
         eS = bbig ? ea : eb;
         r.e = 6'(eB);
         r.sb = bbig ? b[31] : a[31];
         r.mb = 28'((64'd1 << 27) + 64'((bbig ? mb : ma) * 4));
         xs = 28'((64'd1 << 27) + 64'((bbig ? ma : mb) * 4));
         d = eB - eS;
         if (d > 28) d = 28;
         w = {xs, 28'd0} >> d;
         r.ms = w[55:28];
         r.st = |w[27:0];
         r.lat = (d == 0) ? 1 : 1 + (d + STEP - 1) / STEP;
      end
      return r;
   endfunction

   task automatic check_out(string tag, exp_t e);
      chk({tag, ".special"}, 32'(special), 32'(e.sp));
      chk({tag, ".sres"}, special_result, e.sr);
      chk({tag, ".status"}, 32'(status_out), 32'(e.stt));
      chk({tag, ".eff_sub"}, 32'(eff_sub), 32'(e.es));
      if (!e.sp) begin
         chk({tag, ".mant_big"}, 32'(mant_big), 32'(e.mb));
         chk({tag, ".mant_small"}, 32'(mant_small), 32'(e.ms));
         chk({tag, ".sticky"}, 32'(sticky), 32'(e.st));
         chk({tag, ".exp"}, 32'(exp_out), 32'(e.e));
         chk({tag, ".sign_big"}, 32'(sign_big), 32'(e.sb));
         chk({tag, ".swapped"}, 32'(swapped), 32'(e.sw));
      end
   endtask

   task automatic txn(string tag, logic [31:0] a, logic [31:0] b);
      exp_t e;
      int lat;
      e = model(a, b);
      out_ready = 1'b1;
      op_a = a; op_b = b; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 64) begin
         @(posedge clock); #1;
         lat++;
      end
      chk({tag, ".latency"}, 32'(lat), 32'(e.lat));
      check_out(tag, e);
      @(posedge clock); #1;
      chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, ".ready_back"}, 32'(in_ready), 32'd1);
   endtask

   function automatic logic [31:0] rnd_op(int ebase);
      int k, x;
      logic [5:0] e;
      logic [24:0] m;
      k = int'($urandom_range(0, 15));
      m = 25'($urandom);
      x = ebase + int'($urandom_range(0, 40)) - 20;
      if (x < 1) x = 1;
      if (x > 62) x = 62;
      e = 6'(x);
      if (k == 0) e = 6'd0;
      if (k == 1) begin
         e = 6'd63;
         if ($urandom_range(0, 1) == 1) m = 25'd0;
      end
      if (k == 2) m = 25'($urandom_range(0, 3));
      return {1'($urandom), e, m};
   endfunction

   initial begin
      exp_t e;
      int hits, lat, base;
      logic [31:0] ra, rb;

      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.mant_big", 32'(mant_big), 32'd0);
      chk("rst.mant_small", 32'(mant_small), 32'd0);
      chk("rst.sres", special_result, 32'd0);
      chk("rst.status", 32'(status_out), 32'd0);
      chk("rst.flags", 32'({sticky, sign_big, eff_sub, swapped, special}), 32'd0);
      chk("rst.exp", 32'(exp_out), 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      txn("one_half", 32'h3E000000, 32'h3C000000);
      chk("one_half.mb_const", 32'(mant_big), 32'h8000000);
      txn("same_exp", 32'h3E000001, 32'h3E000003);
      txn("clamp", 32'h50000000, 32'h14000001);
      txn("inf_minf", 32'h7E000000, 32'hFE000000);
      txn("zero_nzero", 32'h00000000, 32'h80000000);
      txn("equal", 32'h45123456, 32'h45123456);
      txn("nan", 32'h7E000010, 32'h3E000000);
      txn("one_inf", 32'h3E000000, 32'hFE000000);
      txn("one_zero", 32'h00000000, 32'hBC001234);
      txn("d_eq_step", 32'h3E000000, 32'h36000007);
      txn("d5", 32'h3E000000, 32'h340000FF);

      // backpressure: hold result while a competing pair is offered
      e = model(32'h3E000000, 32'h3C000000);
      out_ready = 1'b0;
      op_a = 32'h3E000000; op_b = 32'h3C000000; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 64) begin
         @(posedge clock); #1;
         lat++;
      end
      chk("bp.latency", 32'(lat), 32'(e.lat));
      op_a = 32'h50000000; op_b = 32'h14000001; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         chk("bp.valid", 32'(out_valid), 32'd1);
         chk("bp.in_ready", 32'(in_ready), 32'd0);
         chk("bp.mant_small", 32'(mant_small), 32'(e.ms));
         chk("bp.mant_big", 32'(mant_big), 32'(e.mb));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      chk("bp.release_ready", 32'(in_ready), 32'd1);
      chk("bp.release_valid", 32'(out_valid), 32'd0);
      @(posedge clock); #1;
      chk("bp.no_accept", 32'(in_ready), 32'd1);

      // reset in the middle of a 20-position alignment
      op_a = 32'h50000000; op_b = 32'h28000000; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      chk("rst_mid.valid", 32'(out_valid), 32'd0);
      chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
      chk("rst_mid.mant_small", 32'(mant_small), 32'd0);
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock); #1;
         if (out_valid) hits++;
      end
      chk("rst_mid.no_output", 32'(hits), 32'd0);
      txn("after_rst", 32'h50000000, 32'h28000000);

      for (int i = 0; i < 60; i++) begin
         base = int'($urandom_range(1, 62));
         ra = rnd_op(base);
         rb = rnd_op(base);
         txn("rand", ra, rb);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
